// File: rtl/prng_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prng_stream_ctrl
// Description : Burst controller that steps an upstream LFSR pair, combines
//               the two bytes (XOR or modulo-256 add) and queues the result
//               in a small registered-head FIFO for downstream draining.
//               Optional build macro PRNG_CHECKSUM_EN adds a per-burst XOR
//               checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int COMBINE    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] burst_len,
  output logic       lfsr_start,
  input  logic       lfsr_ready,
  input  logic [7:0] lfsr1_in,
  input  logic [7:0] lfsr2_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
`ifdef PRNG_CHECKSUM_EN
  output logic [7:0] checksum,
`endif
  output logic [7:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [7:0]    r_out_data;

  logic [7:0]    w_byte;
  logic [7:0]    w_count_inc;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_occ;
  logic [AW-1:0] w_rd_next;
  logic          w_head_new;

  // Byte combine function selected at elaboration time
  generate
    if (COMBINE == 1) begin : g_add
      assign w_byte = lfsr1_in + lfsr2_in;
    end else begin : g_xor
      assign w_byte = lfsr1_in ^ lfsr2_in;
    end
  endgenerate

  // Wrap bit distinguishes full from empty when the index bits match
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push      = (r_state == S_CAPT) && lfsr_ready;
  assign w_pop       = !w_empty && out_ready;
  assign w_rd_next   = r_rd_ptr[AW-1:0] + AW'(w_pop);
  // The pushed byte becomes the head when nothing older survives this cycle
  assign w_head_new  = w_push && (w_occ == (AW+1)'(w_pop));
  assign w_count_inc = r_count + 8'd1;

  assign lfsr_start = (r_state == S_REQ) && !w_full;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign count      = r_count;
  assign out_valid  = !w_empty;
  assign out_data   = r_out_data;

  // Burst sequencing: request, wait for capture, finish on length match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= 8'd0;
      r_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_len   <= burst_len;
            r_count <= 8'd0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!w_full) begin
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (lfsr_ready) begin
            r_count <= w_count_inc;
            // A length of 0 matches when the 8-bit count wraps after 256
            if (w_count_inc == r_len) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
    end
  end

  // Pointer update; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
    end
  end

  // Registered head byte, tracking whichever entry will be at the front
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= 8'd0;
    end else if (w_head_new) begin
      r_out_data <= w_byte;
    end else if (w_pop) begin
      r_out_data <= r_mem[w_rd_next];
    end
  end

`ifdef PRNG_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Running XOR of bytes pushed in the current burst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= 8'd0;
    end else if ((r_state == S_IDLE) && go) begin
      r_checksum <= 8'd0;
    end else if (w_push) begin
      r_checksum <= r_checksum ^ w_byte;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prng_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prng_stream_ctrl
// Description : Directed self-checking bench for prng_stream_ctrl; one XOR
//               instance (depth 4) and one ADD instance. Checksum checks are
//               included when PRNG_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prng_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst, go, go1, lfsr_ready, out_ready, out_ready1, seq_mode;
  logic [7:0] burst_len, a_val, b_val, lfsr1_in, lfsr2_in;
  logic [7:0] step = 8'd0;

  logic       lfsr_start, out_valid, busy, done;
  logic [7:0] out_data, count;
  logic       lfsr_start1, out_valid1, busy1, done1;
  logic [7:0] out_data1, count1;
`ifdef PRNG_CHECKSUM_EN
  logic [7:0] checksum, checksum1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_done   = 0;
  logic [7:0] popq [$];

  always #5 clk = ~clk;

  prng_stream_ctrl #(.FIFO_DEPTH(4), .COMBINE(0)) dut (
    .clk(clk), .rst(rst), .go(go), .burst_len(burst_len),
    .lfsr_start(lfsr_start), .lfsr_ready(lfsr_ready),
    .lfsr1_in(lfsr1_in), .lfsr2_in(lfsr2_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
`ifdef PRNG_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count)
  );

  prng_stream_ctrl #(.FIFO_DEPTH(4), .COMBINE(1)) dut_add (
    .clk(clk), .rst(rst), .go(go1), .burst_len(burst_len),
    .lfsr_start(lfsr_start1), .lfsr_ready(lfsr_ready),
    .lfsr1_in(lfsr1_in), .lfsr2_in(lfsr2_in),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .busy(busy1), .done(done1),
`ifdef PRNG_CHECKSUM_EN
    .checksum(checksum1),
`endif
    .count(count1)
  );

  // Upstream model: step counter advances on each request; in sequence mode
  // the combined byte (XOR with 0) equals the step number.
  always @(posedge clk) step <= step + {7'd0, lfsr_start};

  always_comb begin
    lfsr1_in = seq_mode ? step  : a_val;
    lfsr2_in = seq_mode ? 8'h00 : b_val;
  end

  // Event monitors sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (lfsr_start) n_start <= n_start + 1;
      if (done) n_done <= n_done + 1;
      if (out_valid && out_ready) popq.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] len);
    burst_len = len;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, d, q;
    logic [7:0] s0, e;
    logic [7:0] x;
    rst = 1'b1; go = 1'b0; go1 = 1'b0; lfsr_ready = 1'b0; out_ready = 1'b0;
    out_ready1 = 1'b0; seq_mode = 1'b0; burst_len = 8'd0; a_val = 8'd0; b_val = 8'd0;
    x = 8'd0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",   busy,       0);
    check("rst_valid",  out_valid,  0);
    check("rst_data",   out_data,   0);
    check("rst_start",  lfsr_start, 0);
    check("rst_done",   done,       0);
    check("rst_count",  count,      0);
    check("rst_data1",  out_data1,  0);
`ifdef PRNG_CHECKSUM_EN
    check("rst_csum",   checksum,   0);
`endif
    rst = 1'b0;
    tick();

    // XOR mode, 3 bytes of 0x5A^0x0F
    a_val = 8'h5A; b_val = 8'h0F; lfsr_ready = 1'b1; out_ready = 1'b1;
    s = n_start; d = n_done; q = popq.size();
    start_burst(8'd3);
    wait_idle("t1", 40);
    tick();
    check("t1_starts", n_start - s, 3);
    check("t1_done",   n_done - d,  1);
    check("t1_count",  count,       3);
    check("t1_npop",   popq.size() - q, 3);
    for (int i = 0; i < 3; i++) check("t1_byte", popq[q + i], 8'h55);
    check("t1_empty",  out_valid,   0);
`ifdef PRNG_CHECKSUM_EN
    check("t1_csum",   checksum,    8'h55);
`endif

    // ADD mode, carry dropped: 0xF0 + 0x20 = 0x10
    a_val = 8'hF0; b_val = 8'h20; burst_len = 8'd1; go1 = 1'b1;
    tick();
    go1 = 1'b0;
    for (int k = 0; k < 10 && busy1; k++) tick();
    check("t2_busy",  busy1,      0);
    check("t2_data",  out_data1,  8'h10);
    check("t2_valid", out_valid1, 1);
    check("t2_count", count1,     1);

    // Back-pressure: depth 4 stalls a 6-byte burst, then order preserved
    seq_mode = 1'b1; out_ready = 1'b0;
    s = n_start; d = n_done; q = popq.size(); s0 = step;
    start_burst(8'd6);
    repeat (20) tick();
    check("t3_starts4", n_start - s, 4);
    check("t3_stall",   lfsr_start,  0);
    check("t3_busy",    busy,        1);
    check("t3_count4",  count,       4);
    check("t3_head",    out_data,    s0 + 8'd1);
    // go with a new length while busy must be ignored
    burst_len = 8'd2; go = 1'b1;
    tick();
    go = 1'b0;
    out_ready = 1'b1;
    wait_idle("t3", 60);
    tick();
    check("t3_starts6", n_start - s, 6);
    check("t3_done",    n_done - d,  1);
    check("t3_count6",  count,       6);
    check("t3_npop",    popq.size() - q, 6);
    for (int i = 0; i < 6; i++) begin
      e = s0 + 8'(i + 1);
      x = x ^ e;
      check("t3_order", popq[q + i], e);
    end
`ifdef PRNG_CHECKSUM_EN
    check("t3_csum", checksum, x);
`endif

    // Capture held off by lfsr_ready=0
    seq_mode = 1'b0; a_val = 8'h33; b_val = 8'h11; lfsr_ready = 1'b0; out_ready = 1'b0;
    s = n_start; d = n_done;
    start_burst(8'd1);
    repeat (6) tick();
    check("t4_starts_hold", n_start - s, 1);
    check("t4_nopush",      out_valid,   0);
    check("t4_count_hold",  count,       0);
    check("t4_nostart",     lfsr_start,  0);
    lfsr_ready = 1'b1;
    wait_idle("t4", 10);
    check("t4_count", count,       1);
    check("t4_data",  out_data,    8'h22);
    check("t4_valid", out_valid,   1);
    check("t4_starts", n_start - s, 1);
    check("t4_done",  n_done - d,  1);
    out_ready = 1'b1;
    tick();
    check("t4_drained", out_valid, 0);

    // Reset mid-burst, then a clean burst
    a_val = 8'h5A; b_val = 8'h0F; out_ready = 1'b0;
    d = n_done;
    start_burst(8'd5);
    for (int k = 0; k < 20 && count != 8'd2; k++) tick();
    check("t5_reached2", count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy",  busy,      0);
    check("t5_valid", out_valid, 0);
    check("t5_count", count,     0);
    tick();
    check("t5_nodone", n_done - d, 0);
    out_ready = 1'b1;
    s = n_start; d = n_done; q = popq.size();
    start_burst(8'd2);
    wait_idle("t5", 20);
    tick();
    check("t5_count2",  count,       2);
    check("t5_done2",   n_done - d,  1);
    check("t5_starts2", n_start - s, 2);
    check("t5_npop",    popq.size() - q, 2);
    for (int i = 0; i < 2; i++) check("t5_byte", popq[q + i], 8'h55);

    // burst_len = 0 means 256 captures, count wraps to 0
    s = n_start; d = n_done;
    start_burst(8'd0);
    wait_idle("t6", 1200);
    check("t6_count",  count,       0);
    check("t6_done",   n_done - d,  1);
    check("t6_starts", n_start - s, 256);
`ifdef PRNG_CHECKSUM_EN
    check("t6_csum",   checksum,    0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
